// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: issues sequential reads to a 1-cycle-latency memory and
// buffers {word, pc} in a small FIFO that decode drains over a valid/ready handshake.
module if_prefetch_queue #(
   parameter int             IW       = 12,
   parameter int             AW       = 10,
   parameter int             DEPTH    = 4,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic                       clk1,
   input  logic                       rst_n,
   output logic                       mem_rd_en,
   output logic [AW-1:0]              mem_addr,
   input  logic [IW-1:0]              mem_rdata,
   output logic                       ir_valid,
   input  logic                       ir_ready,
   output logic [IW-1:0]              ir_word,
   output logic [AW-1:0]              ir_pc,
   input  logic                       redirect,
   input  logic [AW-1:0]              redirect_pc,
   input  logic                       skip,
   input  logic                       halt,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Handshake: decode takes the head entry in any cycle where ir_valid and
   // ir_ready are both high; ir_word/ir_pc are stable while ir_valid is held.

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic          active_q;
   logic          inflight_q, inflight_d;
   logic [AW-1:0] infl_pc_q, infl_pc_d;
   logic          infl_epoch_q, infl_epoch_d;
   logic          epoch_q, epoch_d;
   logic          skip_pend_q, skip_pend_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] word_q [DEPTH];
   logic [AW-1:0] pcs_q  [DEPTH];

   logic empty;
   logic issue;
   logic arrival;
   logic drop_arrival;
   logic push;
   logic pop;

   always_comb begin
      empty        = (count_q == '0);
      // active_q holds off the first issue until the cycle after reset release
      issue        = active_q && !halt && !redirect &&
                     (((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
      arrival      = inflight_q && (infl_epoch_q == epoch_q) && !redirect;
      drop_arrival = skip_pend_q || (skip && empty);
      push         = arrival && !drop_arrival;
      pop          = !redirect && !empty && (skip || (ir_ready && !skip_pend_q));

      fetch_pc_d   = fetch_pc_q;
      inflight_d   = issue;
      infl_pc_d    = infl_pc_q;
      infl_epoch_d = infl_epoch_q;
      epoch_d      = epoch_q;
      skip_pend_d  = skip_pend_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;

      if (redirect) begin
         fetch_pc_d  = redirect_pc;
         epoch_d     = ~epoch_q;
         skip_pend_d = 1'b0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
      end else begin
         if (issue) begin
            fetch_pc_d   = fetch_pc_q + AW'(1);
            infl_pc_d    = fetch_pc_q;
            infl_epoch_d = epoch_q;
         end
         // A pending skip is consumed by the first word that actually arrives
         if (arrival) skip_pend_d = 1'b0;
         else         skip_pend_d = skip_pend_q || (skip && empty);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q   <= RESET_PC;
         active_q     <= 1'b0;
         inflight_q   <= 1'b0;
         infl_pc_q    <= '0;
         infl_epoch_q <= 1'b0;
         epoch_q      <= 1'b0;
         skip_pend_q  <= 1'b0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         active_q     <= 1'b1;
         inflight_q   <= inflight_d;
         infl_pc_q    <= infl_pc_d;
         infl_epoch_q <= infl_epoch_d;
         epoch_q      <= epoch_d;
         skip_pend_q  <= skip_pend_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            pcs_q[i]  <= '0;
         end
      end else if (push) begin
         word_q[wr_ptr_q] <= mem_rdata;
         pcs_q[wr_ptr_q]  <= infl_pc_q;
      end
   end

   assign mem_rd_en = issue;
   assign mem_addr  = fetch_pc_q;
   assign ir_valid  = !empty && !skip_pend_q;
   assign ir_word   = word_q[rd_ptr_q];
   assign ir_pc     = pcs_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed test-plan phases followed by random traffic,
// checked against a queue-based model of the fetch/buffer/skip/redirect rules.
module tb_if_prefetch_queue;

   localparam int IW    = 12;
   localparam int AW    = 10;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic           clk1;
   logic           rst_n;
   logic           mem_rd_en;
   logic [AW-1:0]  mem_addr;
   logic [IW-1:0]  mem_rdata;
   logic           ir_valid;
   logic           ir_ready;
   logic [IW-1:0]  ir_word;
   logic [AW-1:0]  ir_pc;
   logic           redirect;
   logic [AW-1:0]  redirect_pc;
   logic           skip;
   logic           halt;
   logic [CW-1:0]  count;

   if_prefetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk1(clk1), .rst_n(rst_n), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .ir_word(ir_word), .ir_pc(ir_pc), .redirect(redirect), .redirect_pc(redirect_pc),
      .skip(skip), .halt(halt), .count(count)
   );

   // clock / reset
   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   // instruction memory with 1-cycle read latency
   logic [IW-1:0] mem_img [0:(1<<AW)-1];
   always @(posedge clk1) if (mem_rd_en) mem_rdata <= mem_img[mem_addr];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // scoreboard: exp_q holds {pc, word} in the order decode must see them
   logic [AW+IW-1:0] exp_q[$];
   logic             m_active, m_inflight, m_skip_pend;
   logic [AW-1:0]    m_pc, m_infl_pc;

   always @(negedge clk1) begin
      logic exp_issue, exp_valid, was_empty;
      if (!rst_n) begin
         check("rst_ir_valid", 32'(ir_valid), 0);
         check("rst_count", 32'(count), 0);
         check("rst_rd_en", 32'(mem_rd_en), 0);
         check("rst_addr", 32'(mem_addr), 0);
         check("rst_head", {ir_pc, ir_word}, 0);
         exp_q.delete();
         m_active = 0; m_inflight = 0; m_skip_pend = 0; m_pc = '0; m_infl_pc = '0;
      end else begin
         exp_issue = m_active && !halt && !redirect && (exp_q.size() + int'(m_inflight) < DEPTH);
         exp_valid = (exp_q.size() > 0) && !m_skip_pend;
         check("ir_valid", 32'(ir_valid), 32'(exp_valid));
         check("count", 32'(count), exp_q.size());
         check("mem_rd_en", 32'(mem_rd_en), 32'(exp_issue));
         if (exp_issue) check("mem_addr", 32'(mem_addr), 32'(m_pc));
         if (exp_valid && ir_valid) check("head", {ir_pc, ir_word}, exp_q[0]);

         // advance the model to the state after the coming rising edge
         if (redirect) begin
            exp_q.delete();
            m_skip_pend = 0;
            m_inflight  = 0;
            m_pc        = redirect_pc;
         end else begin
            was_empty = (exp_q.size() == 0);
            if (!was_empty && (skip || ir_ready)) void'(exp_q.pop_front());
            if (m_inflight) begin
               if (m_skip_pend || (skip && was_empty)) m_skip_pend = 0;
               else exp_q.push_back({m_infl_pc, mem_img[m_infl_pc]});
            end else if (skip && was_empty) begin
               m_skip_pend = 1;
            end
            m_inflight = exp_issue;
            m_infl_pc  = m_pc;
            if (exp_issue) m_pc = m_pc + 1'b1;
         end
         m_active = 1;
      end
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk1);
         #1;
      end
   endtask

   task automatic pulse_redirect(input logic [AW-1:0] pc);
      redirect = 1; redirect_pc = pc;
      step(1);
      redirect = 0;
   endtask

   task automatic pulse_skip();
      skip = 1;
      step(1);
      skip = 0;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_img[i] = IW'($urandom);
      mem_img[0] = 12'h280; mem_img[1] = 12'h181; mem_img[2] = 12'h782;
      mem_img[3] = 12'h788; mem_img[4] = 12'h283; mem_img[5] = 12'h286;
      rst_n = 0; ir_ready = 1; redirect = 0; redirect_pc = '0; skip = 0; halt = 0;
      mem_rdata = '0;
      step(2);
      rst_n = 1;

      // streaming with decode always ready
      step(12);

      // back-pressure until full, then release
      rst_n = 0; step(1); rst_n = 1;
      ir_ready = 0; step(8);
      check("full_count", 32'(count), DEPTH);
      check("full_no_issue", 32'(mem_rd_en), 0);
      ir_ready = 1; step(6);

      // redirect with entries buffered and a read in flight
      ir_ready = 0; step(2);
      pulse_redirect(10'h3FE);
      ir_ready = 1; step(8);

      // skip with a non-empty FIFO
      rst_n = 0; step(1); rst_n = 1;
      ir_ready = 0; step(6);
      ir_ready = 1; step(2);
      pulse_skip();
      step(4);

      // halt drains, skip while empty drops the next arrival
      halt = 1; step(5);
      check("halt_drained", 32'(count), 0);
      pulse_skip();
      halt = 0; step(6);

      // asynchronous reset mid-stream
      ir_ready = 0; step(3);
      #2 rst_n = 0;
      #1;
      check("async_ir_valid", 32'(ir_valid), 0);
      check("async_count", 32'(count), 0);
      step(2);
      rst_n = 1; ir_ready = 1;
      step(8);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         ir_ready    = ($urandom_range(0, 99) < 70);
         halt        = ($urandom_range(0, 99) < 10);
         skip        = ($urandom_range(0, 99) < 5);
         redirect    = ($urandom_range(0, 99) < 3);
         redirect_pc = AW'($urandom);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 0;
            #1 check("rand_async_count", 32'(count), 0);
            step(1);
            rst_n = 1;
         end else begin
            step(1);
         end
      end
      ir_ready = 1; halt = 0; skip = 0; redirect = 0;
      step(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
